// File: rtl/ysyx_23060208_clint_axil.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060208_clint_axil
// Description : AXI-Lite core-local interruptor (msip, 64-bit mtime/mtimecmp)
//               driving the machine timer and software interrupt lines.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060208_clint_axil #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          TICK_DIV   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   clint_araddr,
  input  logic                    clint_arvalid,
  output logic                    clint_arready,
  output logic [DATA_WIDTH-1:0]   clint_rdata,
  output logic [1:0]              clint_rresp,
  output logic                    clint_rvalid,
  input  logic                    clint_rready,
  input  logic [DATA_WIDTH-1:0]   clint_awaddr,
  input  logic                    clint_awvalid,
  output logic                    clint_awready,
  input  logic [DATA_WIDTH-1:0]   clint_wdata,
  input  logic [DATA_WIDTH/8-1:0] clint_wstrb,
  input  logic                    clint_wvalid,
  output logic                    clint_wready,
  output logic [1:0]              clint_bresp,
  output logic                    clint_bvalid,
  input  logic                    clint_bready,
  output logic                    mtip,
  output logic                    msip
);

  localparam logic [15:0] c_off_msip     = 16'h0000;
  localparam logic [15:0] c_off_cmp_lo   = 16'h4000;
  localparam logic [15:0] c_off_cmp_hi   = 16'h4004;
  localparam logic [15:0] c_off_mtime_lo = 16'hBFF8;
  localparam logic [15:0] c_off_mtime_hi = 16'hBFFC;
  localparam logic [1:0]  c_okay         = 2'b00;
  localparam logic [1:0]  c_decerr       = 2'b11;
  localparam int          c_pw           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [0:0] {R_IDLE, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_RESP} w_state_e;

  function automatic logic dec_err(input logic [31:0] a);
    logic hit;
    hit = (a[15:0] == c_off_msip)     || (a[15:0] == c_off_cmp_lo) ||
          (a[15:0] == c_off_cmp_hi)   || (a[15:0] == c_off_mtime_lo) ||
          (a[15:0] == c_off_mtime_hi);
    return (a[31:16] != BASE_ADDR[31:16]) || !hit;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;
  logic        alive_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q, bresp_q;
  logic [31:0] awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d, mtip_q;
  logic [c_pw-1:0] presc_q;

  logic        ar_fire, aw_fire, w_fire, commit, tick;
  logic [31:0] rd_data, wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic [63:0] mtime_inc;

  // Readys stay low until the first edge after reset has been released.
  assign clint_arready = alive_q && (r_state_q == R_IDLE);
  assign clint_awready = alive_q && ((w_state_q == W_IDLE) || (w_state_q == W_W));
  assign clint_wready  = alive_q && ((w_state_q == W_IDLE) || (w_state_q == W_AW));
  assign clint_rvalid  = (r_state_q == R_RESP);
  assign clint_bvalid  = (w_state_q == W_RESP);
  assign clint_rdata   = rdata_q;
  assign clint_rresp   = rresp_q;
  assign clint_bresp   = bresp_q;
  assign mtip          = mtip_q;
  assign msip          = msip_q;

  assign ar_fire   = clint_arvalid && clint_arready;
  assign aw_fire   = clint_awvalid && clint_awready;
  assign w_fire    = clint_wvalid && clint_wready;
  assign tick      = (presc_q == c_pw'(TICK_DIV - 1));
  assign mtime_inc = mtime_q + {63'd0, tick};

  always_comb begin
    rd_data = '0;
    case (clint_araddr[15:0])
      c_off_msip:     rd_data = {31'd0, msip_q};
      c_off_cmp_lo:   rd_data = mtimecmp_q[31:0];
      c_off_cmp_hi:   rd_data = mtimecmp_q[63:32];
      c_off_mtime_lo: rd_data = mtime_q[31:0];
      c_off_mtime_hi: rd_data = mtime_q[63:32];
      default:        rd_data = '0;
    endcase
    if (dec_err(clint_araddr)) rd_data = '0;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_fire) r_state_d = R_RESP;
      R_RESP:  if (clint_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // The half that arrives last comes straight from the bus; the other is latched.
  always_comb begin
    w_state_d = w_state_q;
    wr_addr   = awaddr_q;
    wr_data   = wdata_q;
    wr_strb   = wstrb_q;
    commit    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        wr_addr = clint_awaddr;
        wr_data = clint_wdata;
        wr_strb = clint_wstrb;
        commit  = aw_fire && w_fire;
        if (commit)       w_state_d = W_RESP;
        else if (aw_fire) w_state_d = W_AW;
        else if (w_fire)  w_state_d = W_W;
      end
      W_AW: begin
        wr_data = clint_wdata;
        wr_strb = clint_wstrb;
        commit  = w_fire;
        if (commit) w_state_d = W_RESP;
      end
      W_W: begin
        wr_addr = clint_awaddr;
        commit  = aw_fire;
        if (commit) w_state_d = W_RESP;
      end
      W_RESP:  if (clint_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Written bytes override the ticked value; untouched bytes keep counting.
  always_comb begin
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (commit && !dec_err(wr_addr)) begin
      case (wr_addr[15:0])
        c_off_msip:     if (wr_strb[0]) msip_d = wr_data[0];
        c_off_cmp_lo:   mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wr_data, wr_strb);
        c_off_cmp_hi:   mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wr_data, wr_strb);
        c_off_mtime_lo: mtime_d[31:0]     = merge(mtime_inc[31:0], wr_data, wr_strb);
        c_off_mtime_hi: mtime_d[63:32]    = merge(mtime_inc[63:32], wr_data, wr_strb);
        default:        msip_d = msip_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alive_q    <= 1'b0;
      r_state_q  <= R_IDLE;
      w_state_q  <= W_IDLE;
      rdata_q    <= '0;
      rresp_q    <= c_okay;
      bresp_q    <= c_okay;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      presc_q    <= '0;
    end else begin
      alive_q    <= 1'b1;
      r_state_q  <= r_state_d;
      w_state_q  <= w_state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
      presc_q    <= tick ? '0 : presc_q + 1'b1;
      if (ar_fire) begin
        rdata_q <= rd_data;
        rresp_q <= dec_err(clint_araddr) ? c_decerr : c_okay;
      end
      if (aw_fire) awaddr_q <= clint_awaddr;
      if (w_fire) begin
        wdata_q <= clint_wdata;
        wstrb_q <= clint_wstrb;
      end
      if (commit) bresp_q <= dec_err(wr_addr) ? c_decerr : c_okay;
    end
  end

endmodule
`default_nettype wire
